reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Parametrised successor of the decode-stage register file: configurable data width, register count and number of read ports.
- Adds same-cycle write-back bypass and a per-register pending-write scoreboard, so the decode stage gets its source hazard indication directly from the register file.
- Sits in ID: read ports are driven from instruction source fields, the issue port from the destination of each instruction leaving ID, and the write port from WB.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width
NUM_REGS, 15, number of implemented registers (R0..R14; R15/PC is not stored here)
NUM_RD, 3, number of read ports (Rn, Rm/Rd-for-store, Rs)
CNT_W, 2, width of each per-register outstanding-write counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_valid  in  NUM_RD  port k is a real source this cycle
rd_data  out  NUM_RD*DATA_W  read data, combinational, with bypass
rd_busy  out  NUM_RD  port k register has an outstanding write not yet resolved
hazard  out  1  OR over k of (rd_valid[k] & rd_busy[k])
iss_en  in  1  an instruction with a register write is leaving ID
iss_addr  in  ADDR_W  destination of the issuing instruction
iss_full  out  1  counter of iss_addr is saturated; the issue is refused
wb_en  in  1  write-back enable
wb_addr  in  ADDR_W  write-back destination
wb_data  in  DATA_W  write-back value
flush  in  1  pipeline flush; clears every outstanding-write counter

Behaviour:
- Reset (rst==0 at a rising edge):
  - Reg[i] <= i zero-extended to DATA_W, for i < NUM_REGS.
  - All counters <= 0.
  - After reset, hazard=0, iss_full=0 and rd_busy=0.
- Storage write:
  - On a rising edge with wb_en=1 and wb_addr<NUM_REGS, Reg[wb_addr] <= wb_data.
  - Writes take effect on the rising edge only; there is no negedge write.
- Read path, per port k:
  - If rd_addr >= NUM_REGS, rd_data = 0 and rd_busy = 0.
  - Otherwise, if wb_en=1 and wb_addr==rd_addr, rd_data = wb_data (bypass).
  - Otherwise, rd_data = Reg[rd_addr].
  - Zero cycles of latency.
- Busy computation, per port k:
  - dec = wb_en && wb_addr==rd_addr.
  - rd_busy = (cnt[rd_addr] > dec).
  - A write-back landing this cycle resolves its own pending entry combinationally.
- Counter update for register r, on each rising edge:
  - inc = iss_en && iss_addr==r && !iss_full && !flush.
  - dec = wb_en && wb_addr==r && cnt[r]!=0.
  - If flush: cnt <= 0.
  - Else if inc and not dec: cnt+1.
  - Else if dec and not inc: cnt-1.
  - Otherwise cnt is unchanged.
- Boundary conditions:
  - iss_full = iss_en && iss_addr<NUM_REGS && cnt[iss_addr]==2^CNT_W-1 && !(wb_en && wb_addr==iss_addr). A refused issue leaves the counter unchanged; the hazard unit must stall ID while iss_full=1.
  - Write-back to a register with cnt==0: data is written, the counter stays 0 (no underflow).
  - iss_addr >= NUM_REGS: issue ignored, iss_full=0.
  - Issue and write-back to the same register in one cycle: count unchanged.
  - flush together with wb_en: the data write still occurs and counters go to 0. flush together with iss_en: the issue is dropped.
  - Reset has priority over flush, wb_en and iss_en.
  - Reset mid-operation discards all pending state.
- No internal state machine beyond storage and counters. The block holds no X-state after reset.

Test Plan:
- Reset, rst=0 for 1 cycle, then read ports at addresses 3, 14, 15 -> rd_data = 3, 14, 0; hazard=0.
- Bypass and write: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, read port 0 at addr 5 -> rd_data=0xDEADBEEF in the same cycle; after the edge with wb_en=0, rd_data is still 0xDEADBEEF.
- Scoreboard resolution:
  - iss_en for R2 once; next cycle read R2 with rd_valid=1 -> rd_busy[0]=1, hazard=1.
  - In the cycle wb_en=1 with wb_addr=2 -> rd_busy=0, hazard=0, rd_data=wb_data.
  - After that edge the counter is 0.
- Saturation:
  - Issue R7 three times without write-back -> cnt=3.
  - 4th iss_en -> iss_full=1 and cnt stays 3.
  - 4th issue repeated with wb_en on R7 -> iss_full=0 and cnt stays 3.
- Flush priority: cnt[R1]=2, cnt[R4]=1; assert flush with iss_en on R4 and wb_en on R1 (data 0x55) -> next cycle all counters 0, Reg[1]=0x55, hazard=0.
- Parametrisation: NUM_RD=2, DATA_W=16, NUM_REGS=8 -> reset values 0..7; address 9 reads 0; a write to 9 has no effect.

Source files
------------

// File: rtl/reg_file_scoreboard_if.sv
// Decode/write-back bus of the register file: source reads, destination issue and WB write.
// master = decode/hazard logic side, slave = register file side.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     hazard;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_full;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;

  modport master (
    output rd_addr, rd_valid, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, hazard, iss_full
  );

  modport slave (
    input  rd_addr, rd_valid, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush,
    output rd_data, rd_busy, hazard, iss_full
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Decode-stage register file with write-back bypass and a per-register pending-write
// scoreboard that reports source hazards directly to the decode stage.
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15,
  parameter int NUM_RD   = 3,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_scoreboard_if.slave bus
);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [CNT_W-1:0]         cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]      inc;
  logic [NUM_REGS-1:0]      dec;
  logic                     iss_full;
  logic                     wb_hits_iss;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  // A write-back to the issuing register frees a slot in the same cycle, so it is not full.
  assign wb_hits_iss = bus.wb_en && (bus.wb_addr == bus.iss_addr);

  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    iss_full = 1'b0;
    inc      = '0;
    dec      = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && (&cnt[r]) && !wb_hits_iss)
        iss_full = 1'b1;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && !iss_full && !bus.flush;
      dec[r] = bus.wb_en && (bus.wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
    end
  end

  // Unimplemented addresses match no register and fall through to zero data, not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (bus.rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          if (bus.wb_en && (bus.wb_addr == ADDR_W'(r))) begin
            rd_data[k*DATA_W +: DATA_W] = bus.wb_data;
            rd_busy[k]                  = cnt[r] > CNT_W'(1);
          end else begin
            rd_data[k*DATA_W +: DATA_W] = regs[r];
            rd_busy[k]                  = cnt[r] != '0;
          end
        end
      end
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_busy  = rd_busy;
  assign bus.hazard   = |(bus.rd_valid & rd_busy);
  assign bus.iss_full = iss_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: this array is reset on purpose; each register has a defined reset value (its index).
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= DATA_W'(r);
        cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        // NOTE: non-blocking updates, so every counter decision sees the pre-edge cnt.
        if (bus.wb_en && (bus.wb_addr == ADDR_W'(r)))
          regs[r] <= bus.wb_data;
        if (bus.flush)
          cnt[r] <= '0;
        else if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec[r] && !inc[r])
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomised and directed checks of reg_file_scoreboard against a behavioural register/counter model.
module tb_reg_file_scoreboard;

  localparam int NR   = 15;
  localparam int NRD  = 3;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) bus ();
  reg_file_scoreboard_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus2 ();

  reg_file_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reg_file_scoreboard #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(8), .NUM_RD(2), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int unsigned mreg [NR];
  int          mcnt [NR];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_idle();
    bus.rd_addr  = '0;
    bus.rd_valid = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.flush    = 1'b0;
  endtask

  function automatic bit model_full();
    int ia;
    ia = int'(bus.iss_addr);
    return bus.iss_en && ia < NR && mcnt[ia] == CMAX && !(bus.wb_en && bus.wb_addr == bus.iss_addr);
  endfunction

  // Compare all combinational outputs against what the model predicts for the present inputs.
  task automatic eval_check(input string tag);
    logic [95:0] exp_data;
    logic [2:0]  exp_busy;
    int          a;
    bit          hit;
    exp_data = '0;
    exp_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = int'(bus.rd_addr[k*4 +: 4]);
      if (a < NR) begin
        hit = bus.wb_en && int'(bus.wb_addr) == a;
        exp_data[k*32 +: 32] = hit ? bus.wb_data : mreg[a];
        exp_busy[k]          = mcnt[a] > (hit ? 1 : 0);
      end
    end
    check({tag, ".rd_data"}, 128'(bus.rd_data), 128'(exp_data));
    check({tag, ".rd_busy"}, 128'(bus.rd_busy), 128'(exp_busy));
    check({tag, ".hazard"}, 128'(bus.hazard), 128'(|(exp_busy & bus.rd_valid)));
    check({tag, ".iss_full"}, 128'(bus.iss_full), 128'(model_full()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mreg[i] = i;
      mcnt[i] = 0;
    end
  endtask

  // Advance one clock, applying the register-file rules to the model at the rising edge.
  task automatic tick();
    bit full;
    bit inc;
    bit dec;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      full = model_full();
      for (int r = 0; r < NR; r++) begin
        inc = bus.iss_en && int'(bus.iss_addr) == r && !full && !bus.flush;
        dec = bus.wb_en && int'(bus.wb_addr) == r && mcnt[r] != 0;
        if (bus.flush) mcnt[r] = 0;
        else if (inc && !dec) mcnt[r] = mcnt[r] + 1;
        else if (dec && !inc) mcnt[r] = mcnt[r] - 1;
      end
      if (bus.wb_en && int'(bus.wb_addr) < NR) mreg[bus.wb_addr] = bus.wb_data;
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    set_idle();
    bus2.rd_addr  = '0;
    bus2.rd_valid = '0;
    bus2.iss_en   = 1'b0;
    bus2.iss_addr = '0;
    bus2.wb_en    = 1'b0;
    bus2.wb_addr  = '0;
    bus2.wb_data  = '0;
    bus2.flush    = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Reset values and an unimplemented address.
    bus.rd_addr  = {4'd15, 4'd14, 4'd3};
    bus.rd_valid = 3'b111;
    #1;
    check("reset.rd_data", 128'(bus.rd_data), 128'({32'd0, 32'd14, 32'd3}));
    check("reset.hazard", 128'(bus.hazard), 128'(0));
    check("reset.rd_busy", 128'(bus.rd_busy), 128'(0));
    check("reset.iss_full", 128'(bus.iss_full), 128'(0));
    eval_check("reset");
    tick();

    // Same-cycle bypass, then the stored value after the edge.
    set_idle();
    bus.rd_addr = {4'd0, 4'd0, 4'd5};
    bus.wb_en   = 1'b1;
    bus.wb_addr = 4'd5;
    bus.wb_data = 32'hDEADBEEF;
    #1;
    check("bypass.data", 128'(bus.rd_data[31:0]), 128'(32'hDEADBEEF));
    eval_check("bypass");
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("written.data", 128'(bus.rd_data[31:0]), 128'(32'hDEADBEEF));
    eval_check("written");
    tick();

    // One pending write on R2, resolved by its write-back.
    set_idle();
    bus.iss_en   = 1'b1;
    bus.iss_addr = 4'd2;
    tick();
    set_idle();
    bus.rd_addr  = {4'd15, 4'd15, 4'd2};
    bus.rd_valid = 3'b001;
    #1;
    check("pend.busy", 128'(bus.rd_busy[0]), 128'(1));
    check("pend.hazard", 128'(bus.hazard), 128'(1));
    eval_check("pend");
    tick();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 4'd2;
    bus.wb_data = 32'h0000_1234;
    #1;
    check("resolve.busy", 128'(bus.rd_busy[0]), 128'(0));
    check("resolve.hazard", 128'(bus.hazard), 128'(0));
    check("resolve.data", 128'(bus.rd_data[31:0]), 128'(32'h1234));
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("resolved.busy", 128'(bus.rd_busy[0]), 128'(0));
    eval_check("resolved");
    tick();

    // Saturate R7, refused issue, then issue alongside a write-back.
    set_idle();
    bus.iss_en   = 1'b1;
    bus.iss_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sat.fill_full", 128'(bus.iss_full), 128'(0));
      tick();
    end
    #1;
    check("sat.full", 128'(bus.iss_full), 128'(1));
    tick();
    #1;
    check("sat.still_full", 128'(bus.iss_full), 128'(1));
    bus.wb_en   = 1'b1;
    bus.wb_addr = 4'd7;
    bus.wb_data = 32'h7777_0007;
    #1;
    check("sat.wb_not_full", 128'(bus.iss_full), 128'(0));
    eval_check("sat.wb");
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("sat.cnt_kept", 128'(bus.iss_full), 128'(1));
    eval_check("sat.after");
    set_idle();
    bus.flush = 1'b1;
    tick();

    // Flush priority over issue and counters; write-back data still lands.
    set_idle();
    bus.iss_en = 1'b1;
    bus.iss_addr = 4'd1;
    tick();
    tick();
    bus.iss_addr = 4'd4;
    tick();
    bus.iss_addr = 4'd4;
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 4'd1;
    bus.wb_data  = 32'h55;
    bus.flush    = 1'b1;
    tick();
    set_idle();
    bus.rd_addr  = {4'd7, 4'd4, 4'd1};
    bus.rd_valid = 3'b111;
    #1;
    check("flush.data", 128'(bus.rd_data[31:0]), 128'(32'h55));
    check("flush.busy", 128'(bus.rd_busy), 128'(0));
    check("flush.hazard", 128'(bus.hazard), 128'(0));
    eval_check("flush");
    tick();

    // Randomised traffic, including occasional flush and mid-run reset.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NRD; k++) bus.rd_addr[k*4 +: 4] = rnd_addr();
      bus.rd_valid = 3'($urandom_range(0, 7));
      bus.iss_en   = ($urandom_range(0, 2) != 0);
      bus.iss_addr = rnd_addr();
      bus.wb_en    = ($urandom_range(0, 2) == 0);
      bus.wb_addr  = rnd_addr();
      bus.wb_data  = $urandom;
      bus.flush    = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 79) != 0);
      #1;
      eval_check("rand");
      tick();
    end
    rst = 1'b1;
    set_idle();

    // Narrow configuration: 8 registers, 16-bit data, two read ports.
    bus2.rd_addr = {4'd9, 4'd7};
    #1;
    check("p2.reset_r7", 128'(bus2.rd_data[15:0]), 128'(16'd7));
    check("p2.addr9", 128'(bus2.rd_data[31:16]), 128'(16'd0));
    bus2.wb_en   = 1'b1;
    bus2.wb_addr = 4'd9;
    bus2.wb_data = 16'hBEEF;
    bus2.iss_en  = 1'b1;
    bus2.iss_addr = 4'd9;
    #1;
    check("p2.wb9_bypass", 128'(bus2.rd_data[31:16]), 128'(16'd0));
    check("p2.iss9_full", 128'(bus2.iss_full), 128'(0));
    tick();
    bus2.wb_en   = 1'b0;
    bus2.iss_en  = 1'b0;
    bus2.rd_addr = {4'd9, 4'd1};
    #1;
    check("p2.r1_kept", 128'(bus2.rd_data[15:0]), 128'(16'd1));
    check("p2.addr9_after", 128'(bus2.rd_data[31:16]), 128'(16'd0));
    check("p2.busy", 128'(bus2.rd_busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
